ex_muldiv_seq: RTL and testbench

Multi-cycle sequencer for the RV32M multiply/divide operations issued from the EX stage. It accepts the forwarded rs1/rs2 operands of an M-extension instruction sitting in EX, iterates a shared 1-bit-per-cycle shift-add / restoring-divide datapath, and raises a stall request until the result is ready. In the done cycle the instruction leaves EX with the result. A flush input aborts the operation on a branch redirect or other pipeline kill.

---
 rtl/ex_muldiv_seq_if.sv | 39 +++
 rtl/ex_muldiv_seq.sv | 188 ++++++++++++++++++
 tb/tb_ex_muldiv_seq.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/ex_muldiv_seq_if.sv
// Bundle between the EX stage and the RV32M multiply/divide sequencer.
// The pipeline acts as master: it issues the M-op and the flush, and it observes busy/done/result.
interface ex_muldiv_seq_if #(
    parameter int XLEN = 32
);
    // Handshake: the pipeline raises md_start and keeps the operands stable while md_busy is high.
    // The op completes in the single cycle where md_done=1, and md_result is valid in that cycle.
    // md_flush drops any accepting or in-flight op.
    logic            md_start;
    logic [2:0]      md_func3;
    logic [XLEN-1:0] md_op_a;
    logic [XLEN-1:0] md_op_b;
    logic            md_flush;
    logic            md_busy;
    logic            md_done;
    logic [XLEN-1:0] md_result;

    modport master (
        output md_start,
        output md_func3,
        output md_op_a,
        output md_op_b,
        output md_flush,
        input  md_busy,
        input  md_done,
        input  md_result
    );

    modport slave (
        input  md_start,
        input  md_func3,
        input  md_op_a,
        input  md_op_b,
        input  md_flush,
        output md_busy,
        output md_done,
        output md_result
    );
endinterface

// File: rtl/ex_muldiv_seq.sv
// Iterative RV32M mul/div sequencer: 1 bit per cycle, with a shared shift-add / restoring-divide datapath.
// Define MD_EARLY_OUT_EN to retire divide-by-zero and signed overflow at the accept edge.
module ex_muldiv_seq (
    input  logic                 clk,
    input  logic                 rst,
    ex_muldiv_seq_if.slave       md_if,
    output logic [1:0]           dbg_state_o
);
    localparam int XLEN = 32;

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_REM    = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e          state_q;
    logic [4:0]      cnt_q;
    logic [2:0]      func3_q;
    logic [XLEN-1:0] hi_q;
    logic [XLEN-1:0] lo_q;
    logic [XLEN-1:0] b_q;
    logic            neg_q;
    logic            neg_rem_q;
    logic            spec_q;
    logic [XLEN-1:0] spec_res_q;
    logic [XLEN-1:0] result_q;
    logic            done_q;

    // Accept-time decode, on the raw operands presented by EX
    logic            acc_a_signed;
    logic            acc_b_signed;
    logic            acc_sign_a;
    logic            acc_sign_b;
    logic [XLEN-1:0] acc_mag_a;
    logic [XLEN-1:0] acc_mag_b;
    logic            acc_div_zero;
    logic            acc_div_ovf;
    logic            acc_spec;
    logic [XLEN-1:0] acc_spec_res;

    always_comb begin
        acc_a_signed = md_if.md_func3 inside {F_MUL, F_MULH, F_MULHSU, F_DIV, F_REM};
        acc_b_signed = md_if.md_func3 inside {F_MUL, F_MULH, F_DIV, F_REM};
        acc_sign_a   = acc_a_signed & md_if.md_op_a[XLEN-1];
        acc_sign_b   = acc_b_signed & md_if.md_op_b[XLEN-1];
        acc_mag_a    = acc_sign_a ? (~md_if.md_op_a + 32'd1) : md_if.md_op_a;
        acc_mag_b    = acc_sign_b ? (~md_if.md_op_b + 32'd1) : md_if.md_op_b;
        acc_div_zero = md_if.md_func3[2] && (md_if.md_op_b == 32'd0);
        acc_div_ovf  = (md_if.md_func3 inside {F_DIV, F_REM}) &&
                       (md_if.md_op_a == 32'h8000_0000) &&
                       (md_if.md_op_b == 32'hFFFF_FFFF);
        acc_spec     = acc_div_zero | acc_div_ovf;
        // A set func3[1] selects REM/REMU among the divide ops
        if (acc_div_zero) begin
            acc_spec_res = md_if.md_func3[1] ? md_if.md_op_a : 32'hFFFF_FFFF;
        end else begin
            acc_spec_res = md_if.md_func3[1] ? 32'd0 : 32'h8000_0000;
        end
    end

    // One iteration of the datapath. hi_q holds the accumulator or remainder.
    // lo_q holds the multiplier or the dividend, shifting out as quotient bits shift in.
    logic [XLEN:0]   mul_sum;
    logic [XLEN-1:0] mul_hi_d;
    logic [XLEN-1:0] mul_lo_d;
    logic [XLEN-1:0] div_shift;
    logic [XLEN-1:0] div_sub;
    logic            div_ge;
    logic [XLEN-1:0] div_hi_d;
    logic [XLEN-1:0] div_lo_d;

    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : 33'd0);
        mul_hi_d  = mul_sum[XLEN:1];
        mul_lo_d  = {mul_sum[0], lo_q[XLEN-1:1]};
        // Partial remainder is 33 bits wide; a set top bit already exceeds any 32-bit divisor
        div_shift = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
        div_ge    = hi_q[XLEN-1] | (div_shift >= b_q);
        div_sub   = div_shift - b_q;
        div_hi_d  = div_ge ? div_sub : div_shift;
        div_lo_d  = {lo_q[XLEN-2:0], div_ge};
    end

    // Sign fix-up and result selection
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   mul_res;
    logic [XLEN-1:0]   quo_s;
    logic [XLEN-1:0]   rem_s;
    logic [XLEN-1:0]   div_res;
    logic [XLEN-1:0]   fix_res;

    always_comb begin
        prod_s  = neg_q ? (~{hi_q, lo_q} + 64'd1) : {hi_q, lo_q};
        mul_res = (func3_q == F_MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
        quo_s   = neg_q ? (~lo_q + 32'd1) : lo_q;
        rem_s   = neg_rem_q ? (~hi_q + 32'd1) : hi_q;
        div_res = func3_q[1] ? rem_s : quo_s;
        if (spec_q) begin
            fix_res = spec_res_q;
        end else begin
            fix_res = func3_q[2] ? div_res : mul_res;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 5'd0;
            func3_q    <= 3'd0;
            hi_q       <= '0;
            lo_q       <= '0;
            b_q        <= '0;
            neg_q      <= 1'b0;
            neg_rem_q  <= 1'b0;
            spec_q     <= 1'b0;
            spec_res_q <= '0;
            result_q   <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (md_if.md_flush) begin
                state_q <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (md_if.md_start) begin
                            func3_q    <= md_if.md_func3;
                            hi_q       <= '0;
                            lo_q       <= acc_mag_a;
                            b_q        <= acc_mag_b;
                            neg_q      <= acc_sign_a ^ acc_sign_b;
                            neg_rem_q  <= acc_sign_a;
                            spec_q     <= acc_spec;
                            spec_res_q <= acc_spec_res;
                            cnt_q      <= 5'd0;
`ifdef MD_EARLY_OUT_EN
                            if (acc_spec) begin
                                result_q <= acc_spec_res;
                                done_q   <= 1'b1;
                                state_q  <= S_DONE;
                            end else begin
                                state_q  <= S_CALC;
                            end
`else
                            state_q    <= S_CALC;
`endif
                        end
                    end
                    S_CALC: begin
                        if (func3_q[2]) begin
                            hi_q <= div_hi_d;
                            lo_q <= div_lo_d;
                        end else begin
                            hi_q <= mul_hi_d;
                            lo_q <= mul_lo_d;
                        end
                        cnt_q <= cnt_q + 5'd1;
                        if (cnt_q == 5'd31) begin
                            state_q <= S_FIX;
                        end
                    end
                    S_FIX: begin
                        result_q <= fix_res;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign md_if.md_busy   = md_if.md_start & ~done_q & ~md_if.md_flush;
    assign md_if.md_done   = done_q;
    assign md_if.md_result = result_q;
    assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Scoreboard bench for ex_muldiv_seq: drivers push expected results and done cycles, and a monitor pops them on md_done.
// Define MD_EARLY_OUT_EN to match a DUT that was built with early-out enabled.
module tb_ex_muldiv_seq;
`ifdef MD_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk;
  logic rst;
  logic [1:0] dbg_state;
  int cyc;
  int checks;
  int errors;
  logic [31:0] last_res;
  logic [31:0] exp_q[$];
  int exp_cyc_q[$];

  ex_muldiv_seq_if #(.XLEN(32)) md_if ();

  ex_muldiv_seq dut (
    .clk         (clk),
    .rst         (rst),
    .md_if       (md_if),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s actual=%h expected=%h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // reference model: plain 64-bit integer arithmetic
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    int sa;
    int sb;
    sa = $signed(a);
    sb = $signed(b);
    case (f)
      3'd0: begin p = longint'(sa) * longint'(sb); return p[31:0]; end
      3'd1: begin p = longint'(sa) * longint'(sb); return p[63:32]; end
      3'd2: begin p = longint'(sa) * longint'({32'd0, b}); return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(sa % sb);
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    bit special;
    special = f[2] && ((b == 32'd0) ||
              ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    return (EARLY && special) ? 1 : 34;
  endfunction

  // driver tasks; call at #1 after a rising edge
  task automatic drive(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input bit push, output int lat);
    md_if.md_start = 1'b1;
    md_if.md_func3 = f;
    md_if.md_op_a  = a;
    md_if.md_op_b  = b;
    lat = latency(f, a, b);
    if (push) begin
      exp_q.push_back(model(f, a, b));
      exp_cyc_q.push_back(cyc + lat);
      last_res = model(f, a, b);
    end
  endtask

  task automatic wait_done(input int lat);
    for (int k = 0; k <= lat; k++) begin
      @(negedge clk);
      chk("busy", {31'd0, md_if.md_busy}, {31'd0, (k < lat)});
    end
  endtask

  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input bit keep);
    int lat;
    @(posedge clk); #1;
    drive(f, a, b, 1'b1, lat);
    wait_done(lat);
    if (!keep) begin
      @(posedge clk); #1;
      md_if.md_start = 1'b0;
    end
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // monitor: pops and compares whenever the DUT signals done
  always @(negedge clk) begin
    if (!rst && md_if.md_done) begin
      if (exp_q.size() == 0) begin
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL unexpected_done actual=%h expected=none cycle=%0d", md_if.md_result, cyc);
      end else begin
        chk("result", md_if.md_result, exp_q.pop_front());
        chk("done_cycle", 32'(cyc), 32'(exp_cyc_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    errors = errors + 1;
    $display("FAIL watchdog actual=running expected=finished cycle=%0d", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int lat;
    int acc;
    checks = 0;
    errors = 0;
    last_res = 32'd0;
    rst = 1'b1;
    md_if.md_start = 1'b0;
    md_if.md_func3 = 3'd0;
    md_if.md_op_a  = 32'd0;
    md_if.md_op_b  = 32'd0;
    md_if.md_flush = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_done", {31'd0, md_if.md_done}, 32'd0);
    chk("reset_busy", {31'd0, md_if.md_busy}, 32'd0);
    chk("reset_result", md_if.md_result, 32'd0);

    // directed cases
    run_op(3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 1'b0);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 1'b0);
    run_op(3'd3, 32'h8000_0000, 32'h8000_0000, 1'b0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
    run_op(3'd5, 32'd100, 32'd7, 1'b0);
    run_op(3'd7, 32'd100, 32'd7, 1'b0);
    run_op(3'd5, 32'h1234_5678, 32'd0, 1'b0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(3'd6, 32'hFFFF_FFF0, 32'd0, 1'b0);

    // flush in cycle 10, then DIVU 9/3 accepted in cycle 11
    @(posedge clk); #1;
    drive(3'd0, 32'h0000_1234, 32'h0000_5678, 1'b0, lat);
    acc = cyc;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("flush_busy_pre", {31'd0, md_if.md_busy}, 32'd1);
      @(posedge clk); #1;
    end
    md_if.md_flush = 1'b1;
    @(negedge clk);
    chk("flush_busy", {31'd0, md_if.md_busy}, 32'd0);
    chk("flush_cycle", 32'(cyc - acc), 32'd10);
    @(posedge clk); #1;
    md_if.md_flush = 1'b0;
    chk("flush_result_kept", md_if.md_result, last_res);
    drive(3'd5, 32'd9, 32'd3, 1'b1, lat);
    chk("post_flush_accept", 32'(cyc - acc), 32'd11);
    wait_done(lat);
    @(posedge clk); #1;
    md_if.md_start = 1'b0;

    // reset in cycle 20 of a DIV
    @(posedge clk); #1;
    drive(3'd4, 32'h0001_0000, 32'h0000_0003, 1'b0, lat);
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    md_if.md_start = 1'b0;
    last_res = 32'd0;
    @(negedge clk);
    chk("rst_mid_result", md_if.md_result, 32'd0);
    chk("rst_mid_done", {31'd0, md_if.md_done}, 32'd0);
    repeat (20) @(negedge clk);

    // back-to-back with md_start held
    run_op(3'd0, 32'h0000_0123, 32'hFFFF_FF00, 1'b1);
    run_op(3'd3, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0);

    // randomized ops
    for (int i = 0; i < 40; i++) begin
      run_op(3'($urandom_range(0, 7)), rnd_operand(), rnd_operand(), (i != 39) && ($urandom_range(0, 1) == 1));
    end

    repeat (5) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
